// File: rtl/brc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brc_pkg
//  Description : Shared definitions for the branch/compare arbiter: RISC-V
//                branch funct3 encodings and the requesting-port identifier.
//  Revision    : 1.0  initial release
// ============================================================================
package brc_pkg;

    // Branch funct3 encodings (bit 1 selects unsigned comparison)
    localparam logic [2:0] c_BEQ  = 3'b000;
    localparam logic [2:0] c_BNE  = 3'b001;
    localparam logic [2:0] c_BLT  = 3'b100;
    localparam logic [2:0] c_BGE  = 3'b101;
    localparam logic [2:0] c_BLTU = 3'b110;
    localparam logic [2:0] c_BGEU = 3'b111;

    // Requesting port: 0 = branch unit, 1 = ALU SLT/SLTU
    typedef enum logic {
        PORT_BRANCH = 1'b0,
        PORT_ALU    = 1'b1
    } port_id_t;

endpackage
`default_nettype wire

// File: rtl/brc_cond.sv
`default_nettype none
// ============================================================================
//  Module      : brc_cond
//  Description : Shared comparator (equal / less, signed or unsigned) plus
//                taken decode. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module brc_cond
    import brc_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0] i_rs1,
    input  logic [DATA_SIZE-1:0] i_rs2,
    input  logic                 i_signed,
    input  port_id_t             i_port,
    input  logic [2:0]           i_funct3,
    output logic                 o_equal,
    output logic                 o_less,
    output logic                 o_taken
);

    // Flipping the sign bits turns a two's-complement compare into an
    // unsigned one, so a single magnitude comparator serves both modes.
    logic [DATA_SIZE-1:0] w_rs1_adj;
    logic [DATA_SIZE-1:0] w_rs2_adj;

    assign w_rs1_adj = {i_rs1[DATA_SIZE-1] ^ i_signed, i_rs1[DATA_SIZE-2:0]};
    assign w_rs2_adj = {i_rs2[DATA_SIZE-1] ^ i_signed, i_rs2[DATA_SIZE-2:0]};
    assign o_equal   = (i_rs1 == i_rs2);
    assign o_less    = (w_rs1_adj < w_rs2_adj);

    // Taken decode: ALU port reports less; branch port decodes funct3
    always_comb begin
        o_taken = 1'b0;
        if (i_port == PORT_ALU) begin
            o_taken = o_less;
        end else begin
            case (i_funct3)
                c_BEQ:          o_taken = o_equal;
                c_BNE:          o_taken = !o_equal;
                c_BLT, c_BLTU:  o_taken = o_less;
                c_BGE, c_BGEU:  o_taken = !o_less;
                default:        o_taken = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/brc_arb.sv
`default_nettype none
// ============================================================================
//  Module      : brc_arb
//  Description : Two-port arbiter in front of a shared branch comparator with
//                a one-entry response register (latency 1, full throughput).
//                Build option BRC_ARB_RR_EN: defined -> round-robin on
//                contention; undefined -> fixed priority, port 0 wins.
//  Revision    : 1.0  initial release
// ============================================================================
module brc_arb
    import brc_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req0_valid,
    output logic                 o_req0_ready,
    input  logic [DATA_SIZE-1:0] i_req0_rs1,
    input  logic [DATA_SIZE-1:0] i_req0_rs2,
    input  logic [2:0]           i_req0_funct3,
    input  logic                 i_req1_valid,
    output logic                 o_req1_ready,
    input  logic [DATA_SIZE-1:0] i_req1_rs1,
    input  logic [DATA_SIZE-1:0] i_req1_rs2,
    input  logic                 i_req1_signed,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_id,
    output logic                 o_rsp_equal,
    output logic                 o_rsp_less,
    output logic                 o_rsp_taken
);

    logic                 w_free;
    logic                 w_prefer0;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_accept;
    port_id_t             w_sel;
    logic [DATA_SIZE-1:0] w_rs1;
    logic [DATA_SIZE-1:0] w_rs2;
    logic                 w_signed;
    logic                 w_equal;
    logic                 w_less;
    logic                 w_taken;

    logic                 r_rsp_valid;
    port_id_t             r_rsp_id;
    logic                 r_rsp_equal;
    logic                 r_rsp_less;
    logic                 r_rsp_taken;

`ifdef BRC_ARB_RR_EN
    // 1 = port 1 granted last, so port 0 is preferred on the next contest
    logic r_last_grant;

    assign w_prefer0 = r_last_grant;

    // Last-grant pointer advances on every acceptance
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant1;
        end
    end
`else
    assign w_prefer0 = 1'b1;
`endif

    // Grants depend only on the valids and the preference, never on the
    // other port's ready, so there is no combinational ready loop.
    assign w_free       = !r_rsp_valid || i_rsp_ready;
    assign w_grant0     = i_req0_valid && (!i_req1_valid || w_prefer0);
    assign w_grant1     = i_req1_valid && (!i_req0_valid || !w_prefer0);
    assign o_req0_ready = i_rst_n && w_free && w_grant0;
    assign o_req1_ready = i_rst_n && w_free && w_grant1;
    assign w_accept     = o_req0_ready || o_req1_ready;

    // Steer the granted port's operands into the shared comparator
    assign w_sel    = w_grant1 ? PORT_ALU : PORT_BRANCH;
    assign w_rs1    = w_grant1 ? i_req1_rs1 : i_req0_rs1;
    assign w_rs2    = w_grant1 ? i_req1_rs2 : i_req0_rs2;
    assign w_signed = w_grant1 ? i_req1_signed : !i_req0_funct3[1];

    brc_cond #(
        .DATA_SIZE (DATA_SIZE)
    ) u_cond (
        .i_rs1    (w_rs1),
        .i_rs2    (w_rs2),
        .i_signed (w_signed),
        .i_port   (w_sel),
        .i_funct3 (i_req0_funct3),
        .o_equal  (w_equal),
        .o_less   (w_less),
        .o_taken  (w_taken)
    );

    // Response register: load on accept, clear valid when drained, hold data
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= PORT_BRANCH;
            r_rsp_equal <= 1'b0;
            r_rsp_less  <= 1'b0;
            r_rsp_taken <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_sel;
            r_rsp_equal <= w_equal;
            r_rsp_less  <= w_less;
            r_rsp_taken <= w_taken;
        end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_equal = r_rsp_equal;
    assign o_rsp_less  = r_rsp_less;
    assign o_rsp_taken = r_rsp_taken;

endmodule
`default_nettype wire
